// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, raises flush/new_pc on exceptions and ERET,
// holds flush for a drain period and runs a stall watchdog. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter int          FLUSH_CYCLES  = 1,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy_flush,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_exc_cnt
);

  // state | meaning
  // RUN   | normal flow; stalls merged, exceptions accepted (Mealy flush)
  // DRAIN | flush held for the remaining drain cycles; exceptions ignored
  typedef enum logic {RUN, DRAIN} state_t;

  localparam int DW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [31:0] ERET_CODE = 32'hE;

  state_t       state;
  logic [DW-1:0] drain_cnt;
  logic [31:0]  new_pc_q;
  logic [15:0]  wd_cnt;
  logic [15:0]  wd_inc;
  logic [5:0]   stall_req;
  logic [31:0]  exc_target;
  logic         exc_take;

  assign exc_take   = (state == RUN) && (excepttype != 32'h0);
  assign exc_target = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;

  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      if (state == DRAIN) begin
        flush  = 1'b1;
        new_pc = new_pc_q;
      end else if (exc_take) begin
        flush  = 1'b1;
        new_pc = exc_target;
      end else begin
        stall  = stall_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      drain_cnt  <= '0;
      new_pc_q   <= 32'h0;
      busy_flush <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exc_take) begin
            new_pc_q <= exc_target;
            if (FLUSH_CYCLES > 1) begin
              state      <= DRAIN;
              drain_cnt  <= DRAIN_INIT;
              busy_flush <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= RUN;
            busy_flush <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state      <= RUN;
          busy_flush <= 1'b0;
        end
      endcase
    end
  end

  assign wd_inc = (wd_cnt == 16'hFFFF) ? 16'hFFFF : wd_cnt + 16'd1;

  // The flag sets on the edge where the count reaches the limit, not one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt        <= 16'h0;
      stall_timeout <= 1'b0;
    end else if ((stall == 6'b000000) || flush) begin
      wd_cnt <= 16'h0;
    end else begin
      wd_cnt <= wd_inc;
      if ((STALL_TIMEOUT != 16'h0) && (wd_inc == STALL_TIMEOUT))
        stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= 32'h0;
      perf_exc_cnt   <= 32'h0;
    end else begin
      if (stall != 6'b000000) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (exc_take)           perf_exc_cnt   <= perf_exc_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cyc = 32'h0;
  assign perf_exc_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a default instance plus one with FLUSH_CYCLES=3, STALL_TIMEOUT=4.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;

  logic [5:0]  stall_d, stall_3;
  logic        flush_d, flush_3, busy_d, busy_3, to_d, to_3;
  logic [31:0] new_pc_d, new_pc_3, psc_d, psc_3, pec_d, pec_3;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
  } obs_t;

  obs_t  sb_q[$];
  string sbn_q[$];

  always #5 clk = ~clk;

  pipe_ctrl u_def (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall_d), .flush(flush_d), .new_pc(new_pc_d), .busy_flush(busy_d),
    .stall_timeout(to_d), .perf_stall_cyc(psc_d), .perf_exc_cnt(pec_d)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(16'd4)) u_f3 (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall_3), .flush(flush_3), .new_pc(new_pc_3), .busy_flush(busy_3),
    .stall_timeout(to_3), .perf_stall_cyc(psc_3), .perf_exc_cnt(pec_3)
  );

  task automatic set_idle();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype = 32'h0; cp0_epc = 32'h0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, a, m;
    string n;
    rst = 1'b0;
    stallreq_mem = 1; excepttype = 32'h8; cp0_epc = 32'h1234;
    sb_q.push_back('{6'b0, 1'b0, 32'h0, 1'b0}); sbn_q.push_back("reset_forced");
    #3;
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    checks++;
    if ({stall_3, flush_3, new_pc_3} !== 39'h0) begin
      errors++; $display("FAIL reset_forced_f3 got %h exp 0", {stall_3, flush_3, new_pc_3});
    end
    set_idle();
    @(posedge clk); #1 rst = 1'b1;
    sb_q.push_back('{6'b0, 1'b0, 32'h0, 1'b0}); sbn_q.push_back("reset_idle");
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    checks++;
    if ({to_d, to_3, psc_3, pec_3} !== 66'h0) begin
      errors++; $display("FAIL reset_flags got %h exp 0", {to_d, to_3, psc_3, pec_3});
    end
  endtask

  task automatic test_stall_priority();
    // {if,id,ex,mem} request pattern and the merged vector expected for it
    logic [3:0] req [6] = '{4'b0101, 4'b0100, 4'b0110, 4'b1000, 4'b1100, 4'b1111};
    logic [5:0] exp [6] = '{6'b011111, 6'b000111, 6'b001111, 6'b000011, 6'b000111, 6'b011111};
    obs_t e, a, m;
    string n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req[i];
      sb_q.push_back('{exp[i], 1'b0, 32'h0, 1'b0}); sbn_q.push_back($sformatf("stall_prio_%0d", i));
      #2;
      e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
      m = '{6'h3F, 1'b1, 32'h0, 1'b1};
      checks++;
      if ((a & m) !== (e & m)) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    end
    set_idle();
  endtask

  task automatic test_exception();
    obs_t e, a, m;
    string n;
    do_reset();
    stallreq_ex = 1; excepttype = 32'h8;
    sb_q.push_back('{6'b0, 1'b1, 32'hBFC00380, 1'b0}); sbn_q.push_back("exc_vector");
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    @(posedge clk); #1 excepttype = 32'h0;
    sb_q.push_back('{6'b001111, 1'b0, 32'h0, 1'b0}); sbn_q.push_back("exc_one_cycle");
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    m = '{6'h3F, 1'b1, 32'h0, 1'b1};
    checks++;
    if ((a & m) !== (e & m)) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    set_idle();
  endtask

  task automatic test_eret();
    obs_t e, a, m;
    string n;
    do_reset();
    stallreq_mem = 1; excepttype = 32'hE; cp0_epc = 32'h80001234;
    sb_q.push_back('{6'b0, 1'b1, 32'h80001234, 1'b0}); sbn_q.push_back("eret_epc");
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    obs_t e, a, m;
    string n;
    do_reset();
    excepttype = 32'h8; cp0_epc = 32'h80004000;
    sb_q.push_back('{6'b0, 1'b1, 32'hBFC00380, 1'b0}); sbn_q.push_back("b2b_first");
    sb_q.push_back('{6'b0, 1'b1, 32'h80004000, 1'b0}); sbn_q.push_back("b2b_second_eret");
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    @(posedge clk); #1 excepttype = 32'hE;
    @(negedge clk);
    e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_d, flush_d, new_pc_d, busy_d};
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %h exp %h", n, a, e); end
    set_idle();
  endtask

  task automatic test_drain();
    obs_t e, a;
    string n;
    do_reset();
    excepttype = 32'hC;
    sb_q.push_back('{6'b0, 1'b1, 32'hBFC00380, 1'b0}); sbn_q.push_back("drain_c1");
    sb_q.push_back('{6'b0, 1'b1, 32'hBFC00380, 1'b1}); sbn_q.push_back("drain_c2_ignored");
    sb_q.push_back('{6'b0, 1'b1, 32'hBFC00380, 1'b1}); sbn_q.push_back("drain_c3");
    sb_q.push_back('{6'b0, 1'b0, 32'h0, 1'b0});        sbn_q.push_back("drain_done");
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin excepttype = 32'hE; cp0_epc = 32'h12345678; stallreq_mem = 1; end
      if (c == 2) begin excepttype = 32'h0; stallreq_mem = 0; end
      @(negedge clk);
      e = sb_q.pop_front(); n = sbn_q.pop_front(); a = {stall_3, flush_3, new_pc_3, busy_3};
      checks++;
      if ((e.flush && a !== e) || (!e.flush && {a.stall, a.flush, a.busy} !== {e.stall, e.flush, e.busy})) begin
        errors++; $display("FAIL %s got %h exp %h", n, a, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pec_3 !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL drain_perf_exc got %0d exp %0d", pec_3, PERF ? 1 : 0);
    end
    // Reset mid-DRAIN must drop flush without waiting for a clock edge.
    excepttype = 32'h8;
    @(posedge clk); #1 excepttype = 32'h0;
    #1;
    checks++;
    if ({flush_3, busy_3} !== 2'b11) begin
      errors++; $display("FAIL mid_drain_pre got %b exp 11", {flush_3, busy_3});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({flush_3, busy_3, new_pc_3} !== 34'h0) begin
      errors++; $display("FAIL mid_drain_reset got %h exp 0", {flush_3, busy_3, new_pc_3});
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({flush_3, busy_3} !== 2'b00) begin
      errors++; $display("FAIL mid_drain_after got %b exp 00", {flush_3, busy_3});
    end
    set_idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    stallreq_mem = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (to_3 !== (k >= 4)) begin
        errors++; $display("FAIL wd_cycle_%0d got %b exp %b", k, to_3, (k >= 4));
      end
    end
    stallreq_mem = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({to_3, to_d} !== 2'b10) begin
      errors++; $display("FAIL wd_sticky got %b exp 10", {to_3, to_d});
    end
    checks++;
    if (psc_3 !== (PERF ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL wd_perf_stall got %0d exp %0d", psc_3, PERF ? 5 : 0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (to_3 !== 1'b0) begin
      errors++; $display("FAIL wd_reset_clear got %b exp 0", to_3);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret();
    test_back_to_back();
    test_drain();
    test_watchdog();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
